// File: rtl/spi_byte_sequencer.sv
// Byte sequencer in front of spi_master: turns a valid/ready tx stream into one
// start/done transaction per byte and returns each received byte on an rx stream.
module spi_byte_sequencer #(
    parameter int         GAP_CYCLES     = 4,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [1:0] CDIV           = 2'b00,
    parameter logic       MSB_FIRST      = 1'b1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_last,
    output logic       spi_start,
    output logic [7:0] spi_tdat,
    output logic [1:0] spi_cdiv,
    output logic       spi_mlb,
    input  logic       spi_done,
    input  logic [7:0] spi_rdata,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

    localparam logic [15:0] WD_MAX  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_MAX = 8'(GAP_CYCLES - 1);

    state_t      state;
    logic        last_r;
    logic [15:0] wd;
    logic [7:0]  gap;
    logic        done_m, done_s;
    logic [7:0]  rdata_m, rdata_s;
    logic        wd_fire;

    assign spi_cdiv = CDIV;
    assign spi_mlb  = MSB_FIRST;

    // Master updates on negedge; these flops free-run so reset never fakes a done edge.
    always_ff @(posedge clk) begin
        done_m  <= spi_done;
        done_s  <= done_m;
        rdata_m <= spi_rdata;
        rdata_s <= rdata_m;
    end

    assign wd_fire = ((state == S_ISSUE) || (state == S_WAIT)) && (wd == WD_MAX);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= 8'h00;
            rx_last     <= 1'b0;
            spi_start   <= 1'b0;
            spi_tdat    <= 8'hFF;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            last_r      <= 1'b0;
            wd          <= '0;
            gap         <= '0;
        end else begin
            // A fresh timeout beats a simultaneous clear.
            if (wd_fire)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        spi_tdat  <= tx_data;
                        last_r    <= tx_last;
                        tx_ready  <= 1'b0;
                        spi_start <= 1'b1;
                        busy      <= 1'b1;
                        wd        <= '0;
                        state     <= S_ISSUE;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    wd <= wd + 16'd1;
                    if (wd_fire) begin
                        // Poisoned byte keeps the frame aligned downstream.
                        spi_start <= 1'b0;
                        rx_data   <= 8'hFF;
                        rx_last   <= last_r;
                        rx_valid  <= 1'b1;
                        state     <= S_RESP;
                    end else if ((state == S_ISSUE) && !done_s) begin
                        spi_start <= 1'b0;
                        state     <= S_WAIT;
                    end else if ((state == S_WAIT) && done_s) begin
                        rx_data  <= rdata_s;
                        rx_last  <= last_r;
                        rx_valid <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        gap      <= '0;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap == GAP_MAX) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        gap <= gap + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer with a small behavioural spi_master model and an rx scoreboard.
module tb_spi_byte_sequencer;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       tx_valid = 1'b0, tx_last = 1'b0, rx_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, rx_last, spi_start, spi_mlb, busy, err_timeout;
    logic [7:0] rx_data, spi_tdat;
    logic [1:0] spi_cdiv;
    logic       m_done = 1'b1;
    logic [7:0] m_rdata = 8'h00, m_tdat = 8'h00;
    int         m_cnt = 0;
    int         mode = 0;   // 0 loopback, 1 fixed 8'h3C, 2 done stuck high
    int         tests = 0, fails = 0, n_starts = 0;
    logic       start_d = 1'b0;
    logic [8:0] sb_q[$];
    logic [8:0] sb_exp;

    spi_byte_sequencer #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16), .CDIV(2'b11), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rstb(rstb), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_last(tx_last), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_last(rx_last), .spi_start(spi_start), .spi_tdat(spi_tdat), .spi_cdiv(spi_cdiv),
        .spi_mlb(spi_mlb), .spi_done(m_done), .spi_rdata(m_rdata), .busy(busy),
        .err_timeout(err_timeout), .err_clr(err_clr));

    always #5 clk = ~clk;

    // spi_master model: takes start when idle, 6-cycle transfer, state moves on negedge
    always @(negedge clk) begin
        if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                m_done  <= 1'b1;
                m_rdata <= (mode == 0) ? m_tdat : 8'h3C;
            end
            m_cnt <= m_cnt - 1;
        end else if (spi_start && mode != 2) begin
            m_done <= 1'b0;
            m_cnt  <= 6;
            m_tdat <= spi_tdat;
        end
    end

    always @(negedge clk) begin
        if (spi_start && !start_d) n_starts++;
        start_d = spi_start;
    end

    // Scoreboard: pop and compare on every rx handshake
    always @(negedge clk) begin
        if (rstb && rx_valid && rx_ready) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected got last=%0b data=%h, nothing expected", rx_last, rx_data);
            end else begin
                sb_exp = sb_q.pop_front();
                if ({rx_last, rx_data} !== sb_exp) begin
                    fails++;
                    $display("FAIL sb_rx got last=%0b data=%h exp last=%0b data=%h",
                             rx_last, rx_data, sb_exp[8], sb_exp[7:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input bit push, output bit ok);
        int n = 0;
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin @(posedge clk); #1; n++; end
        ok = tx_ready;
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        if (ok && push) sb_q.push_back({l, (mode == 0) ? d : (mode == 1) ? 8'h3C : 8'hFF});
    endtask

    task automatic wait_rx(output bit ok);
        int n = 0;
        while (!rx_valid && n < 200) begin @(posedge clk); #1; n++; end
        ok = rx_valid;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while ((busy || !tx_ready) && n < 200) begin @(posedge clk); #1; n++; end
        ok = !busy && tx_ready;
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({tx_ready, rx_valid, rx_data, rx_last, spi_start, spi_tdat, busy, err_timeout} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_vals got rdy=%0b rv=%0b rd=%h rl=%0b st=%0b td=%h bsy=%0b err=%0b",
                     tx_ready, rx_valid, rx_data, rx_last, spi_start, spi_tdat, busy, err_timeout);
        end
        tests++;
        if (spi_cdiv !== 2'b11 || spi_mlb !== 1'b1) begin
            fails++; $display("FAIL const_out got cdiv=%b mlb=%b exp 11 1", spi_cdiv, spi_mlb);
        end
        rstb = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_release tx_ready=%b exp 1", tx_ready); end
    endtask

    task automatic test_single;
        bit ok;
        mode = 0; rx_ready = 1'b1;
        send(8'hA5, 1'b1, 1'b1, ok);
        tests++;
        if (!ok || spi_start !== 1'b1 || tx_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_start ok=%0b start=%b rdy=%b busy=%b exp 1 1 0 1", ok, spi_start, tx_ready, busy);
        end
        wait_rx(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_rx_timeout rx_valid=%b exp 1", rx_valid); end
        @(posedge clk); #1;   // rx handshake edge
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL single_gap_early busy=%b exp 1", busy); end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || tx_ready !== 1'b1 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL single_gap_end busy=%b rdy=%b err=%b exp 0 1 0", busy, tx_ready, err_timeout);
        end
    endtask

    task automatic test_frame;
        logic [7:0] fb [3] = '{8'h01, 8'h80, 8'hFF};
        bit ok;
        int bad, n;
        mode = 1; rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(fb[i], (i == 2), 1'b1, ok);
            bad = 0; n = 0;
            while (!rx_valid && n < 200) begin
                if (tx_ready) bad++;
                @(posedge clk); #1; n++;
            end
            tests++;
            if (!ok || !rx_valid || bad != 0) begin
                fails++;
                $display("FAIL frame_byte%0d ok=%0b rx_valid=%b tx_ready_high=%0d exp 1 1 0", i, ok, rx_valid, bad);
            end
        end
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL frame_idle busy=%b exp 0", busy); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int bad = 0, s0;
        mode = 0; rx_ready = 1'b0;
        send(8'h5A, 1'b0, 1'b1, ok);
        wait_rx(ok);
        s0 = n_starts;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_last !== 1'b0 || tx_ready !== 1'b0) bad++;
        end
        tests++;
        if (!ok || bad != 0 || n_starts != s0) begin
            fails++;
            $display("FAIL backpressure ok=%0b bad_cycles=%0d new_starts=%0d exp 1 0 0", ok, bad, n_starts - s0);
        end
        rx_ready = 1'b1;
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_idle busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_wait;
        bit ok;
        int n = 0;
        mode = 0; rx_ready = 1'b1;
        send(8'h77, 1'b1, 1'b0, ok);
        while (spi_start && n < 50) begin @(posedge clk); #1; n++; end
        tests++;
        if (!ok || spi_start !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL rstwait_enter start=%b busy=%b exp 0 1", spi_start, busy);
        end
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        tests++;
        if ({tx_ready, rx_valid, rx_data, rx_last, spi_start, spi_tdat, busy, err_timeout} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rstwait_vals got rdy=%0b rv=%0b rd=%h rl=%0b st=%0b td=%h bsy=%0b err=%0b",
                     tx_ready, rx_valid, rx_data, rx_last, spi_start, spi_tdat, busy, err_timeout);
        end
        @(posedge clk); #1;
        tests++;
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL rstwait_ready tx_ready=%b exp 1", tx_ready); end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_timeout;
        bit ok;
        int bad = 0;
        mode = 2; rx_ready = 1'b0;
        send(8'h12, 1'b1, 1'b1, ok);
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            if (spi_start !== 1'b1 || rx_valid !== 1'b0 || err_timeout !== 1'b0) bad++;
        end
        tests++;
        if (!ok || bad != 0) begin fails++; $display("FAIL timeout_early ok=%0b bad_cycles=%0d exp 1 0", ok, bad); end
        @(posedge clk); #1;
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hFF || rx_last !== 1'b1 || err_timeout !== 1'b1 || spi_start !== 1'b0) begin
            fails++;
            $display("FAIL timeout_fire rv=%b rd=%h rl=%b err=%b st=%b exp 1 ff 1 1 0",
                     rx_valid, rx_data, rx_last, err_timeout, spi_start);
        end
        rx_ready = 1'b1;
        wait_idle(ok);
        tests++;
        if (!ok || err_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky err=%b exp 1", err_timeout); end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        tests++;
        if (err_timeout !== 1'b0) begin fails++; $display("FAIL timeout_clr err=%b exp 0", err_timeout); end
    endtask

    task automatic test_set_clr;
        bit ok;
        mode = 2; rx_ready = 1'b1;
        send(8'h34, 1'b0, 1'b1, ok);
        repeat (15) begin @(posedge clk); #1; end
        tests++;
        if (!ok || err_timeout !== 1'b0) begin fails++; $display("FAIL setclr_pre err=%b exp 0", err_timeout); end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        tests++;
        if (err_timeout !== 1'b1 || rx_valid !== 1'b1) begin
            fails++; $display("FAIL setclr_win err=%b rv=%b exp 1 1", err_timeout, rx_valid);
        end
        wait_idle(ok);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        mode = 0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_frame;
        test_backpressure;
        test_reset_wait;
        test_timeout;
        test_set_clr;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin fails++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
